// File: rtl/mux3_bus_arbiter.sv
// mux3_bus_arbiter: round-robin burst arbiter that shares one datapath between
// three requesters and a single valid/ready consumer.
// A grant covers a whole burst and is released on the owner's last beat.
// Optional feature: define ARB_BURST_LIMIT_EN to force a release after
// MAX_BURST beats and to add the one-cycle preempt output.

module mux3_bus_arbiter_mux #(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] inp1,
    input  logic [DATA_W-1:0] inp2,
    input  logic [DATA_W-1:0] inp3,
    output logic [DATA_W-1:0] out
);

    // 3:1 select; the unused code 2'b11 falls back to inp1
    always_comb begin
        case (sel)
            2'b01:   out = inp2;
            2'b10:   out = inp3;
            default: out = inp1;
        endcase
    end

endmodule

module mux3_bus_arbiter #(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req,
    input  logic [2:0]        last,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              out_ready,
    output logic [2:0]        gnt,
    output logic [2:0]        req_ready,
    output logic [1:0]        sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  beat_cnt
`ifdef ARB_BURST_LIMIT_EN
    ,
    output logic              preempt
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

`ifdef ARB_BURST_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_BURST - 1);

    state_t     state;
    state_t     state_next;
    logic [1:0] rr_ptr;
    logic [1:0] winner;
    logic       fire;
    logic       limit_hit;
    logic       rel_burst;

    mux3_bus_arbiter_mux #(.DATA_W(DATA_W)) u_mux (
        .sel  (sel),
        .inp1 (data0),
        .inp2 (data1),
        .inp3 (data2),
        .out  (out_data)
    );

    // Cyclic search for the first active request starting at rr_ptr
    always_comb begin
        winner = 2'd0;
        case (rr_ptr)
            2'd1: begin
                if (req[1])      winner = 2'd1;
                else if (req[2]) winner = 2'd2;
                else             winner = 2'd0;
            end
            2'd2: begin
                if (req[2])      winner = 2'd2;
                else if (req[0]) winner = 2'd0;
                else             winner = 2'd1;
            end
            default: begin
                if (req[0])      winner = 2'd0;
                else if (req[1]) winner = 2'd1;
                else             winner = 2'd2;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state: any request starts a burst, a releasing beat ends it
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req != 3'b000) state_next = BUSY;
            BUSY:    if (rel_burst)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs; the owner is identified by the registered select
    always_comb begin
        out_valid = (state == BUSY) && req[sel];
        fire      = out_valid && out_ready;
        req_ready = gnt & {3{out_ready}};
        limit_hit = LIMIT_EN && (beat_cnt == LIMIT_M1);
        rel_burst = fire && (last[sel] || limit_hit);
    end

    // Grant, select, round-robin pointer and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= 3'b000;
            sel      <= 2'b00;
            rr_ptr   <= 2'd0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 3'b000) begin
                        gnt      <= 3'(3'b001 << winner);
                        sel      <= winner;
                        beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (fire && (beat_cnt != {CNT_W{1'b1}}))
                        beat_cnt <= beat_cnt + 1'b1;
                    if (rel_burst) begin
                        gnt    <= 3'b000;
                        rr_ptr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_BURST_LIMIT_EN
    // One-cycle pulse when the beat limit rather than last ends the burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) preempt <= 1'b0;
        else        preempt <= rel_burst && !last[sel];
    end
`endif

endmodule

// File: tb/tb_mux3_bus_arbiter.sv
// tb_mux3_bus_arbiter: self-checking bench for mux3_bus_arbiter with a
// cycle-level behavioural model plus directed literal expectations.

module tb_mux3_bus_arbiter;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int MAX_B  = 4;
`ifdef ARB_BURST_LIMIT_EN
    localparam bit LIMIT_ON = 1'b1;
`else
    localparam bit LIMIT_ON = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [2:0]        req;
    logic [2:0]        last;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              out_ready;
    logic [2:0]        gnt;
    logic [2:0]        req_ready;
    logic [1:0]        sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  beat_cnt;
    logic              preempt;

    int tests = 0;
    int fails = 0;
    bit check_en = 0;

    // model state
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_cnt   = 0;
    bit m_pre   = 0;
    bit found;

    logic [2:0] exp_gnt2 [8];
    int         exp_sel2 [8];

    mux3_bus_arbiter #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .MAX_BURST (MAX_B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .out_ready (out_ready),
        .gnt       (gnt),
        .req_ready (req_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
`ifdef ARB_BURST_LIMIT_EN
        .preempt   (preempt),
`endif
        .beat_cnt  (beat_cnt)
    );

`ifndef ARB_BURST_LIMIT_EN
    assign preempt = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: who owns the bus, how many beats, where the pointer is
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_sel   = 0;
            m_cnt   = 0;
            m_pre   = 0;
        end else begin
            m_pre = 0;
            if (m_owner < 0) begin
                if (req != 3'b000) begin
                    found = 0;
                    for (int k = 0; k < 3; k++) begin
                        if (!found && req[(m_ptr + k) % 3]) begin
                            m_owner = (m_ptr + k) % 3;
                            found   = 1;
                        end
                    end
                    m_sel = m_owner;
                    m_cnt = 0;
                end
            end else if (req[m_owner] && out_ready) begin
                if (m_cnt < 15) m_cnt = m_cnt + 1;
                if (last[m_owner] || (LIMIT_ON && m_cnt == MAX_B)) begin
                    m_pre   = !last[m_owner];
                    m_ptr   = (m_owner + 1) % 3;
                    m_owner = -1;
                end
            end
        end
    end

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        logic [2:0]  e_gnt;
        logic [31:0] e_data;
        logic        e_valid;
        e_gnt   = (m_owner >= 0) ? 3'(3'b001 << m_owner) : 3'b000;
        e_valid = (m_owner >= 0) && req[m_owner];
        e_data  = (m_sel == 0) ? data0 : (m_sel == 1) ? data1 : data2;
        checkValue("model gnt", {29'd0, gnt}, {29'd0, e_gnt});
        checkValue("model sel", {30'd0, sel}, 32'(m_sel));
        checkValue("model beat_cnt", {28'd0, beat_cnt}, 32'(m_cnt));
        checkValue("model out_valid", {31'd0, out_valid}, {31'd0, e_valid});
        checkValue("model req_ready", {29'd0, req_ready}, {29'd0, e_gnt & {3{out_ready}}});
        checkValue("model out_data", out_data, e_data);
        if (LIMIT_ON) checkValue("model preempt", {31'd0, preempt}, {31'd0, m_pre});
    endtask

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    // Drive one cycle of inputs and return 2 time units after the next rising edge
    task automatic applyStimulus(input logic [2:0] r, input logic [2:0] l, input logic rdy);
        req       = r;
        last      = l;
        out_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req   = 3'b000;
        last  = 3'b000;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        exp_gnt2 = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        exp_sel2 = '{0, 0, 1, 1, 2, 2, 0, 0};

        rst_n     = 1'b0;
        req       = 3'b000;
        last      = 3'b000;
        out_ready = 1'b0;
        data0     = 32'h0000_0002;
        data1     = 32'hFFFF_FFFA;
        data2     = 32'h55AA_AAAA;
        #12;
        checkValue("reset gnt", {29'd0, gnt}, 32'h0);
        checkValue("reset sel", {30'd0, sel}, 32'h0);
        checkValue("reset beat_cnt", {28'd0, beat_cnt}, 32'h0);
        checkValue("reset out_valid", {31'd0, out_valid}, 32'h0);
        checkValue("reset out_data", out_data, 32'h2);
        check_en = 1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single requester, three-beat burst
        applyStimulus(3'b001, 3'b000, 1'b1);
        checkValue("t1 gnt", {29'd0, gnt}, 32'h1);
        checkValue("t1 sel", {30'd0, sel}, 32'h0);
        checkValue("t1 out_data", out_data, 32'h2);
        applyStimulus(3'b001, 3'b000, 1'b1);
        checkValue("t1 beat1", {28'd0, beat_cnt}, 32'd1);
        applyStimulus(3'b001, 3'b000, 1'b1);
        checkValue("t1 beat2", {28'd0, beat_cnt}, 32'd2);
        applyStimulus(3'b001, 3'b001, 1'b1);
        checkValue("t1 beat3", {28'd0, beat_cnt}, 32'd3);
        checkValue("t1 release gnt", {29'd0, gnt}, 32'h0);
        applyStimulus(3'b011, 3'b010, 1'b1);
        checkValue("t1 ptr1 gnt", {29'd0, gnt}, 32'h2);
        applyStimulus(3'b010, 3'b010, 1'b1);

        // 2: all three requesting with single-beat bursts
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'b111, 3'b111, 1'b1);
            checkValue("t2 gnt", {29'd0, gnt}, {29'd0, exp_gnt2[i]});
            checkValue("t2 sel", {30'd0, sel}, 32'(exp_sel2[i]));
            if (exp_sel2[i] == 2) checkValue("t2 out_data", out_data, 32'h55AA_AAAA);
        end

        // 3: backpressure on owner 1
        doReset();
        applyStimulus(3'b010, 3'b000, 1'b1);
        applyStimulus(3'b010, 3'b000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b010, 3'b000, 1'b0);
            checkValue("t3 frozen cnt", {28'd0, beat_cnt}, 32'd1);
            checkValue("t3 gnt held", {29'd0, gnt}, 32'h2);
            checkValue("t3 out_valid", {31'd0, out_valid}, 32'h1);
            checkValue("t3 out_data", out_data, 32'hFFFF_FFFA);
        end
        applyStimulus(3'b010, 3'b000, 1'b1);
        checkValue("t3 resume cnt", {28'd0, beat_cnt}, 32'd2);
        applyStimulus(3'b010, 3'b010, 1'b1);

        // 4: owner 2 stalls while requester 0 waits
        doReset();
        applyStimulus(3'b100, 3'b000, 1'b1);
        checkValue("t4 gnt", {29'd0, gnt}, 32'h4);
        applyStimulus(3'b101, 3'b000, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(3'b001, 3'b000, 1'b1);
            checkValue("t4 stall gnt", {29'd0, gnt}, 32'h4);
            checkValue("t4 stall valid", {31'd0, out_valid}, 32'h0);
            checkValue("t4 stall cnt", {28'd0, beat_cnt}, 32'd1);
        end
        applyStimulus(3'b101, 3'b100, 1'b1);
        checkValue("t4 release", {29'd0, gnt}, 32'h0);
        applyStimulus(3'b001, 3'b000, 1'b1);
        checkValue("t4 req0 gnt", {29'd0, gnt}, 32'h1);
        applyStimulus(3'b001, 3'b001, 1'b1);

        // 5: asynchronous reset in the middle of a burst
        doReset();
        applyStimulus(3'b010, 3'b000, 1'b1);
        applyStimulus(3'b010, 3'b000, 1'b1);
        applyStimulus(3'b010, 3'b000, 1'b1);
        checkValue("t5 pre cnt", {28'd0, beat_cnt}, 32'd2);
        rst_n = 1'b0;
        #1;
        checkValue("t5 gnt", {29'd0, gnt}, 32'h0);
        checkValue("t5 sel", {30'd0, sel}, 32'h0);
        checkValue("t5 cnt", {28'd0, beat_cnt}, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(3'b011, 3'b000, 1'b1);
        checkValue("t5 restart gnt", {29'd0, gnt}, 32'h1);
        applyStimulus(3'b011, 3'b001, 1'b1);

`ifdef ARB_BURST_LIMIT_EN
        // 6: burst limit forces release after MAX_B beats
        doReset();
        applyStimulus(3'b001, 3'b000, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(3'b001, 3'b000, 1'b1);
        checkValue("t6 cnt", {28'd0, beat_cnt}, 32'd4);
        checkValue("t6 release", {29'd0, gnt}, 32'h0);
        checkValue("t6 preempt", {31'd0, preempt}, 32'h1);
        applyStimulus(3'b001, 3'b000, 1'b1);
        checkValue("t6 preempt end", {31'd0, preempt}, 32'h0);
        checkValue("t6 regrant", {29'd0, gnt}, 32'h1);
        applyStimulus(3'b001, 3'b000, 1'b1);
        applyStimulus(3'b001, 3'b001, 1'b1);
        checkValue("t6 tail cnt", {28'd0, beat_cnt}, 32'd2);
        checkValue("t6 tail release", {29'd0, gnt}, 32'h0);
`endif

        applyStimulus(3'b000, 3'b000, 1'b1);
        check_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
